// File: rtl/reg_file_pkg.sv
// Shared defaults and MIPS ABI register indices for the scoreboarded register file.
package reg_file_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int MAX_PEND_DEF = 8;

    typedef enum logic [4:0] {
        ZERO, AT, V0, V1, A0, A1, A2, A3,
        T0, T1, T2, T3, T4, T5, T6, T7,
        S0, S1, S2, S3, S4, S5, S6, S7,
        T8, T9, K0, K1, GP, SP, FP, RA
    } abi_reg_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for outstanding write-backs, with occupancy count and
// a sticky flag for write-backs that arrive for a register nobody reserved.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int MAX_PEND = MAX_PEND_DEF,
    localparam int NREGS   = 1 << ADDR_W,
    localparam int CNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic              rd_a_busy,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic              rd_b_busy,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              wb_fire,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [CNT_W-1:0]  busy_cnt,
    output logic              wb_err
);

    localparam bit             ZR      = (ZERO_REG != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREGS-1:0] busy;
    logic             rsv_zero;
    logic             clr;

    assign rd_a_busy = busy[rd_a_addr];
    assign rd_b_busy = busy[rd_b_addr];

    // Registered busy only: a register being cleared this cycle is still refused.
    assign rsv_zero = ZR && (rsv_addr == '0);
    assign rsv_ok   = rsv_en && !busy[rsv_addr] && (busy_cnt < CNT_MAX) && !rsv_zero;
    assign clr      = wb_fire && busy[wb_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            wb_err   <= 1'b0;
        end else begin
            if (clr)
                busy[wb_addr] <= 1'b0;
            if (rsv_ok)
                busy[rsv_addr] <= 1'b1;
            case ({rsv_ok, clr})
                2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
                2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
                default: busy_cnt <= busy_cnt;
            endcase
            if (wb_fire && !busy[wb_addr])
                wb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with a handshaked write-back port,
// write-to-read bypass and a reservation scoreboard for outstanding write-backs.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int MAX_PEND = MAX_PEND_DEF,
    localparam int CNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_busy,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  busy_cnt,
    output logic              wb_err
);

    localparam int NREGS = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_valid;
    logic              wb_fire;
    logic              wb_write;

    // A CPU write to the hardwired zero register is a no-op and does not stall write-back.
    assign wr_valid = wr_en && !(ZR && (wr_addr == '0));
    assign wb_ready = !wr_valid;
    assign wb_fire  = wb_valid && wb_ready;
    assign wb_write = wb_fire && !(ZR && (wb_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            if (wr_valid)
                regs[wr_addr] <= wr_data;
            if (wb_write)
                regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [DATA_W-1:0] bypass(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_hit_en,
        input logic [ADDR_W-1:0] wr_hit_addr,
        input logic [DATA_W-1:0] wr_hit_data,
        input logic              wb_hit_en,
        input logic [ADDR_W-1:0] wb_hit_addr,
        input logic [DATA_W-1:0] wb_hit_data
    );
        if (ZR && (addr == '0))
            return '0;
        if (wr_hit_en && (wr_hit_addr == addr))
            return wr_hit_data;
        if (wb_hit_en && (wb_hit_addr == addr))
            return wb_hit_data;
        return stored;
    endfunction

    assign rd_a_data = bypass(rd_a_addr, regs[rd_a_addr], wr_valid, wr_addr, wr_data,
                              wb_write, wb_addr, wb_data);
    assign rd_b_data = bypass(rd_b_addr, regs[rd_b_addr], wr_valid, wr_addr, wr_data,
                              wb_write, wb_addr, wb_data);

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .MAX_PEND (MAX_PEND)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (rd_a_addr),
        .rd_a_busy (rd_a_busy),
        .rd_b_addr (rd_b_addr),
        .rd_b_busy (rd_b_busy),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ok    (rsv_ok),
        .wb_fire   (wb_fire),
        .wb_addr   (wb_addr),
        .busy_cnt  (busy_cnt),
        .wb_err    (wb_err)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized checks of reg_file_sb against a register/busy-set model.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int MAXP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_a_addr, rd_b_addr, wr_addr, rsv_addr, wb_addr;
    logic [31:0] rd_a_data, rd_b_data, wr_data, wb_data;
    logic        rd_a_busy, rd_b_busy, wr_en, rsv_en, rsv_ok, wb_valid, wb_ready, wb_err;
    logic [3:0]  busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];
    bit          merr;
    bit          wb_hold;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_a_busy (rd_a_busy),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b_data),
        .rd_b_busy (rd_b_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rsv_ok    (rsv_ok),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy_cnt  (busy_cnt),
        .wb_err    (wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (mbusy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit wr_ok, input bit wb_acc);
        if (a == 5'd0) return 32'h0;
        if (wr_ok && wr_addr == a) return wr_data;
        if (wb_acc && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
        merr    = 1'b0;
        wb_hold = 1'b0;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        rsv_en   = 1'b0;
        wb_valid = 1'b0;
    endtask

    // Checks every output against the model just before the edge, then advances the model.
    task automatic cycle(input string tag);
        bit wr_ok, wb_acc, rok;
        @(negedge clk);
        wr_ok  = wr_en && (wr_addr != 5'd0);
        wb_acc = wb_valid && !wr_ok;
        rok    = rsv_en && !mbusy[rsv_addr] && (busy_count() < MAXP) && (rsv_addr != 5'd0);
        check({tag, "/rd_a_data"}, rd_a_data, exp_read(rd_a_addr, wr_ok, wb_acc));
        check({tag, "/rd_b_data"}, rd_b_data, exp_read(rd_b_addr, wr_ok, wb_acc));
        check({tag, "/rd_a_busy"}, 32'(rd_a_busy), 32'(mbusy[rd_a_addr]));
        check({tag, "/rd_b_busy"}, 32'(rd_b_busy), 32'(mbusy[rd_b_addr]));
        check({tag, "/wb_ready"}, 32'(wb_ready), 32'(!wr_ok));
        check({tag, "/rsv_ok"}, 32'(rsv_ok), 32'(rok));
        check({tag, "/busy_cnt"}, 32'(busy_cnt), 32'(busy_count()));
        check({tag, "/wb_err"}, 32'(wb_err), 32'(merr));
        @(posedge clk);
        #1;
        if (wr_ok) mregs[wr_addr] = wr_data;
        if (wb_acc) begin
            if (wb_addr != 5'd0) mregs[wb_addr] = wb_data;
            if (mbusy[wb_addr]) mbusy[wb_addr] = 1'b0;
            else merr = 1'b1;
        end
        if (rok) mbusy[rsv_addr] = 1'b1;
        wb_hold = wb_valid && !wb_acc;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_a_addr = 5'd3; rd_b_addr = 5'd7;
        wr_addr = 5'd0; wr_data = 32'h0; rsv_addr = 5'd0; wb_addr = 5'd0; wb_data = 32'h0;
        model_reset();
        #2;
        check("reset/busy_cnt", 32'(busy_cnt), 32'd0);
        check("reset/wb_err", 32'(wb_err), 32'd0);
        check("reset/rd_a_data", rd_a_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // r0 stays zero and a write to it does not stall write-back
        idle(); wr_en = 1'b1; wr_addr = ZERO; wr_data = 32'hDEADBEEF; rd_a_addr = ZERO; rd_b_addr = ZERO;
        #1;
        check("r0_wr/bypass", rd_a_data, 32'h0);
        check("r0_wr/wb_ready", 32'(wb_ready), 32'd1);
        cycle("r0_wr");
        idle(); #1; check("r0_rd/data", rd_a_data, 32'h0); cycle("r0_rd");

        // write bypass then stored value
        idle(); wr_en = 1'b1; wr_addr = T0; wr_data = 32'h1234; rd_a_addr = T0;
        #1; check("r8_wr/bypass", rd_a_data, 32'h1234); cycle("r8_wr");
        idle(); #1; check("r8_rd/array", rd_a_data, 32'h1234); cycle("r8_rd");

        // reserve r9, then write it back
        idle(); rsv_en = 1'b1; rsv_addr = T1; rd_b_addr = T1;
        #1; check("r9_rsv/rsv_ok", 32'(rsv_ok), 32'd1); cycle("r9_rsv");
        idle(); #1;
        check("r9_busy/rd_b_busy", 32'(rd_b_busy), 32'd1);
        check("r9_busy/busy_cnt", 32'(busy_cnt), 32'd1);
        wb_valid = 1'b1; wb_addr = T1; wb_data = 32'hA5A5;
        #1; check("r9_wb/bypass", rd_b_data, 32'hA5A5); cycle("r9_wb");
        idle(); #1;
        check("r9_done/busy", 32'(rd_b_busy), 32'd0);
        check("r9_done/data", rd_b_data, 32'hA5A5);
        check("r9_done/busy_cnt", 32'(busy_cnt), 32'd0);
        cycle("r9_done");

        // CPU write stalls a same-cycle write-back by one cycle
        idle(); rsv_en = 1'b1; rsv_addr = A1; cycle("r5_rsv");
        idle(); wr_en = 1'b1; wr_addr = A0; wr_data = 32'h4444_0004;
        wb_valid = 1'b1; wb_addr = A1; wb_data = 32'h5555_0005; rd_a_addr = A0; rd_b_addr = A1;
        #1;
        check("stall/wb_ready", 32'(wb_ready), 32'd0);
        check("stall/rd_b_old", rd_b_data, 32'h0);
        cycle("stall");
        wr_en = 1'b0;
        #1; check("stall_rel/wb_ready", 32'(wb_ready), 32'd1); cycle("stall_rel");
        idle(); #1;
        check("stall_done/r4", rd_a_data, 32'h4444_0004);
        check("stall_done/r5", rd_b_data, 32'h5555_0005);
        cycle("stall_done");

        // fill the scoreboard
        for (int i = 0; i < MAXP; i++) begin
            idle(); rsv_en = 1'b1; rsv_addr = 5'(16 + i);
            #1; check("fill/rsv_ok", 32'(rsv_ok), 32'd1); cycle("fill");
        end
        idle(); rsv_en = 1'b1; rsv_addr = T8;
        #1;
        check("full/rsv_ok", 32'(rsv_ok), 32'd0);
        check("full/busy_cnt", 32'(busy_cnt), 32'd8);
        cycle("full");
        idle(); rsv_en = 1'b1; rsv_addr = S0; wb_valid = 1'b1; wb_addr = S0; wb_data = 32'h1600_0016;
        rd_a_addr = S0;
        #1; check("same_clr/rsv_ok", 32'(rsv_ok), 32'd0); cycle("same_clr");
        idle(); #1;
        check("same_clr/busy_cnt", 32'(busy_cnt), 32'd7);
        check("same_clr/busy", 32'(rd_a_busy), 32'd0);
        rsv_en = 1'b1; rsv_addr = S0; wb_valid = 1'b1; wb_addr = S1; wb_data = 32'h1700_0017;
        #1; check("swap/rsv_ok", 32'(rsv_ok), 32'd1); cycle("swap");
        idle(); #1; check("swap/busy_cnt", 32'(busy_cnt), 32'd7); cycle("swap_after");
        for (int i = 0; i < MAXP; i++) begin
            if (i == 1) continue;
            idle(); wb_valid = 1'b1; wb_addr = 5'(16 + i); wb_data = $urandom; cycle("drain");
        end
        idle(); #1; check("drain/busy_cnt", 32'(busy_cnt), 32'd0); cycle("drained");

        // write-back to a register nobody reserved
        idle(); wb_valid = 1'b1; wb_addr = T4; wb_data = 32'hC0FFEE12; rd_a_addr = T4;
        #1; check("err/before", 32'(wb_err), 32'd0); cycle("err_wb");
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("err/sticky", 32'(wb_err), 32'd1);
            check("err/r12", rd_a_data, 32'hC0FFEE12);
            check("err/busy_cnt", 32'(busy_cnt), 32'd0);
            cycle("err_hold");
        end

        // asynchronous reset in the middle of activity
        idle(); rsv_en = 1'b1; rsv_addr = V1; cycle("pre_rst_rsv");
        idle(); wr_en = 1'b1; wr_addr = A2; wr_data = 32'h6666; cycle("pre_rst_wr");
        idle(); rd_a_addr = V1; rd_b_addr = A2;
        #2; rst = 1'b1; #1;
        check("mid_rst/rd_a", rd_a_data, 32'h0);
        check("mid_rst/rd_b", rd_b_data, 32'h0);
        check("mid_rst/busy", 32'(rd_a_busy), 32'd0);
        check("mid_rst/busy_cnt", 32'(busy_cnt), 32'd0);
        check("mid_rst/wb_err", 32'(wb_err), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(); wb_valid = 1'b1; wb_addr = V1; wb_data = 32'h3333; cycle("post_rst_wb");
        idle(); #1; check("post_rst/wb_err", 32'(wb_err), 32'd1); cycle("post_rst");

        // randomized traffic with a clean start
        rst = 1'b1; #1; model_reset(); @(posedge clk); #1; rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 1) == 0);
            rsv_addr = 5'($urandom_range(0, 31));
            if (!wb_hold) begin
                wb_valid = ($urandom_range(0, 2) != 0);
                wb_addr  = 5'($urandom_range(0, 31));
                wb_data  = $urandom;
                if ($urandom_range(0, 9) < 8 && busy_count() > 0) begin
                    int pick = $urandom_range(0, busy_count() - 1);
                    for (int i = 0; i < 32; i++)
                        if (mbusy[i]) begin
                            if (pick == 0) wb_addr = 5'(i);
                            pick--;
                        end
                end
            end
            case ($urandom_range(0, 3))
                0:       rd_a_addr = wr_addr;
                1:       rd_a_addr = wb_addr;
                default: rd_a_addr = 5'($urandom_range(0, 31));
            endcase
            rd_b_addr = ($urandom_range(0, 1) == 0) ? wb_addr : 5'($urandom_range(0, 31));
            cycle("rand");
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
